safe_attempt_ctrl: RTL and testbench

SAFE_ATTEMPT_CTRL -- requirements
Module: safe_attempt_ctrl

---
 rtl/safe_attempt_ctrl_pkg.sv | 21 ++
 rtl/safe_attempt_ctrl_if.sv | 29 ++
 rtl/safe_attempt_ctrl_key_edge_detect.sv | 39 +++
 rtl/safe_attempt_ctrl.sv | 119 +++++++++++
 tb/tb_safe_attempt_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_attempt_ctrl_pkg.sv
// Shared definitions for the safe attempt controller: FSM states, key indices
// and default limits.
package safe_attempt_ctrl_pkg;

    localparam int KEY_W                  = 12;
    localparam int CLEAR_KEY_IDX          = 10;
    localparam int DEFAULT_MAX_FAILS      = 3;
    localparam int DEFAULT_LOCKOUT_CYCLES = 20;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    function automatic logic isDigit(input logic [3:0] idx);
        return idx <= 4'd9;
    endfunction

endpackage

// File: rtl/safe_attempt_ctrl_if.sv
// Code-presentation handshake between the keypad controller and the safe core.
interface safe_attempt_ctrl_if;

    logic        code_valid;
    logic [15:0] code;
    logic        cmp_ready;
    logic        cmp_done;
    logic        cmp_match;
    logic        safe_locked;

    modport master (
        output code_valid,
        output code,
        input  cmp_ready,
        input  cmp_done,
        input  cmp_match,
        input  safe_locked
    );

    modport slave (
        input  code_valid,
        input  code,
        output cmp_ready,
        output cmp_done,
        output cmp_match,
        output safe_locked
    );

endinterface

// File: rtl/safe_attempt_ctrl_key_edge_detect.sv
// Turns the raw one-hot keypad into single-cycle press events: a key counts
// once, on the cycle it rises, and only if no other key is down.
module key_edge_detect
    import safe_attempt_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_valid,
    output logic [3:0]       o_idx
);

    logic [KEY_W-1:0] r_prevKey;
    logic [KEY_W-1:0] w_rise;
    logic             w_oneHot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevKey <= '0;
        end else begin
            r_prevKey <= i_key;
        end
    end

    assign w_rise   = i_key & ~r_prevKey;
    assign w_oneHot = $onehot(i_key);
    // With a one-hot key, any rising bit must be the single bit that is set.
    assign o_valid  = w_oneHot && (|w_rise);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (i_key[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/safe_attempt_ctrl.sv
// Keypad attempt controller: collects four BCD digits, presents them to the
// safe core, counts consecutive wrong codes and enforces a timed lockout.
module safe_attempt_ctrl
    import safe_attempt_ctrl_pkg::*;
#(
    parameter int MAX_FAILS      = DEFAULT_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_W-1:0]    i_key,
    safe_attempt_ctrl_if.master cmp_bus,
    output logic [2:0]          o_digits_entered,
    output logic [2:0]          o_fail_cnt,
    output logic                o_lockout
);

    localparam logic [2:0]  MAX_FAILS_W  = 3'(MAX_FAILS);
    localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]  CLEAR_IDX    = 4'(CLEAR_KEY_IDX);

    state_t      r_state;
    logic [15:0] r_code;
    logic [2:0]  r_digits;
    logic [2:0]  r_failCnt;
    logic [15:0] r_timer;
    logic        r_codeValid;
    logic        r_lockout;

    logic        w_keyValid;
    logic [3:0]  w_keyIdx;
    logic [2:0]  w_failNext;

    key_edge_detect u_key_edge_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (i_key),
        .o_valid (w_keyValid),
        .o_idx   (w_keyIdx)
    );

    assign w_failNext = (r_failCnt >= MAX_FAILS_W) ? MAX_FAILS_W : r_failCnt + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_COLLECT;
            r_code      <= '0;
            r_digits    <= '0;
            r_failCnt   <= '0;
            r_timer     <= '0;
            r_codeValid <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_keyValid) begin
                        if (isDigit(w_keyIdx)) begin
                            r_code <= {r_code[11:0], w_keyIdx};
                            if (r_digits == 3'd3) begin
                                r_digits    <= 3'd4;
                                r_codeValid <= 1'b1;
                                r_state     <= ST_REQ;
                            end else begin
                                r_digits <= r_digits + 3'd1;
                            end
                        end else if (w_keyIdx == CLEAR_IDX) begin
                            r_digits <= '0;
                            r_code   <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (r_codeValid && cmp_bus.cmp_ready) begin
                        r_codeValid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An unlocked safe accepts anything, so only a locked mismatch is a failure.
                    if (cmp_bus.cmp_done) begin
                        r_digits <= '0;
                        if (cmp_bus.cmp_match || !cmp_bus.safe_locked) begin
                            r_failCnt <= '0;
                            r_state   <= ST_COLLECT;
                        end else begin
                            r_failCnt <= w_failNext;
                            if (w_failNext == MAX_FAILS_W) begin
                                r_timer   <= LOCKOUT_LOAD;
                                r_lockout <= 1'b1;
                                r_state   <= ST_LOCKOUT;
                            end else begin
                                r_state <= ST_COLLECT;
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == 16'd0) begin
                        r_failCnt <= '0;
                        r_lockout <= 1'b0;
                        r_state   <= ST_COLLECT;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign cmp_bus.code_valid = r_codeValid;
    assign cmp_bus.code       = r_code;
    assign o_digits_entered   = r_digits;
    assign o_fail_cnt         = r_failCnt;
    assign o_lockout          = r_lockout;

endmodule

// File: tb/tb_safe_attempt_ctrl.sv
// Self-checking bench for safe_attempt_ctrl: directed scenarios plus random
// attempts scored against an attempt-level model of the failure counter.
module tb_safe_attempt_ctrl;
    import safe_attempt_ctrl_pkg::*;

    localparam int MAXF  = 3;
    localparam int LOCKN = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [KEY_W-1:0] key;
    logic [2:0]       digitsEntered;
    logic [2:0]       failCnt;
    logic             lockout;

    int checkCount = 0;
    int passCount  = 0;
    int mFail      = 0;

    safe_attempt_ctrl_if bus ();

    safe_attempt_ctrl #(
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCKN)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_key            (key),
        .cmp_bus          (bus.master),
        .o_digits_entered (digitsEntered),
        .o_fail_cnt       (failCnt),
        .o_lockout        (lockout)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [KEY_W-1:0] k, input int hold);
        key = k;
        repeat (hold) tick();
        key = '0;
        tick();
    endtask

    task automatic pressDigit(input int d, input int hold);
        logic [KEY_W-1:0] k;
        k = 12'b1 << d;
        applyStimulus(k, hold);
    endtask

    task automatic pulseDone(input logic match, input logic locked);
        bus.cmp_match   = match;
        bus.safe_locked = locked;
        bus.cmp_done    = 1'b1;
        tick();
        bus.cmp_done    = 1'b0;
        bus.cmp_match   = 1'b0;
    endtask

    task automatic enterAndSubmit(input logic [15:0] codeBcd, input int readyDelay, input string tag);
        logic [KEY_W-1:0] k;
        bus.cmp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pressDigit(int'(codeBcd[15-4*i -: 4]), int'($urandom_range(1, 3)));
        end
        checkOutput({tag, ".valid"}, 32'(bus.code_valid), 1);
        checkOutput({tag, ".code"}, 32'(bus.code), 32'(codeBcd));
        checkOutput({tag, ".digits"}, 32'(digitsEntered), 4);
        for (int c = 0; c < readyDelay; c++) begin
            k = 12'b1 << $urandom_range(0, 9);
            key = (c == 1) ? k : '0;
            tick();
            checkOutput({tag, ".holdValid"}, 32'(bus.code_valid), 1);
            checkOutput({tag, ".holdCode"}, 32'(bus.code), 32'(codeBcd));
        end
        key = '0;
        bus.cmp_ready = 1'b1;
        tick();
        bus.cmp_ready = 1'b0;
        checkOutput({tag, ".xfer"}, 32'(bus.code_valid), 0);
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic checkLockout(input string tag);
        int n;
        logic [KEY_W-1:0] k;
        n = 0;
        checkOutput({tag, ".lockFail"}, 32'(failCnt), MAXF);
        while (lockout === 1'b1 && n < LOCKN + 10) begin
            k = 12'b1 << $urandom_range(0, 9);
            if (n == LOCKN - 1) key = 12'h020;
            else key = ($urandom_range(0, 1) == 1) ? k : '0;
            checkOutput({tag, ".lockDigits"}, 32'(digitsEntered), 0);
            n++;
            tick();
        end
        checkOutput({tag, ".lockLen"}, 32'(n), LOCKN);
        checkOutput({tag, ".lockExitFail"}, 32'(failCnt), 0);
        checkOutput({tag, ".exitKeyIgnored"}, 32'(digitsEntered), 0);
        key = '0;
        tick();
        mFail = 0;
    endtask

    task automatic doAttempt(input logic [15:0] codeBcd, input int readyDelay,
                             input logic match, input logic locked, input string tag);
        bit lockExp;
        enterAndSubmit(codeBcd, readyDelay, tag);
        pulseDone(match, locked);
        lockExp = 1'b0;
        if (match || !locked) begin
            mFail = 0;
        end else begin
            mFail++;
            if (mFail == MAXF) lockExp = 1'b1;
        end
        checkOutput({tag, ".digitsAfter"}, 32'(digitsEntered), 0);
        if (lockExp) begin
            checkOutput({tag, ".lockOn"}, 32'(lockout), 1);
            checkLockout(tag);
        end else begin
            checkOutput({tag, ".fail"}, 32'(failCnt), 32'(mFail));
            checkOutput({tag, ".noLock"}, 32'(lockout), 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, 32'(bus.code_valid), 0);
        checkOutput({tag, ".code"}, 32'(bus.code), 0);
        checkOutput({tag, ".digits"}, 32'(digitsEntered), 0);
        checkOutput({tag, ".fail"}, 32'(failCnt), 0);
        checkOutput({tag, ".lock"}, 32'(lockout), 0);
    endtask

    initial begin
        logic [15:0] rc;
        rst_n           = 1'b0;
        key             = 12'h008;
        bus.cmp_ready   = 1'b0;
        bus.cmp_done    = 1'b0;
        bus.cmp_match   = 1'b0;
        bus.safe_locked = 1'b1;
        repeat (3) tick();
        checkAllZero("reset");

        // A key already held at reset release is accepted on the first edge.
        rst_n = 1'b1;
        tick();
        checkOutput("firstKey.digits", 32'(digitsEntered), 1);
        key = '0;
        tick();
        applyStimulus(12'h400, 1);
        checkOutput("clearAfterFirst.digits", 32'(digitsEntered), 0);
        checkOutput("clearAfterFirst.code", 32'(bus.code), 0);

        // Wrong code with the core always ready: code_valid lasts one cycle.
        bus.cmp_ready = 1'b1;
        pressDigit(1, 2);
        pressDigit(2, 2);
        pressDigit(3, 2);
        key = 12'h010;
        tick();
        checkOutput("wrong.valid", 32'(bus.code_valid), 1);
        checkOutput("wrong.code", 32'(bus.code), 32'h1234);
        tick();
        checkOutput("wrong.validFall", 32'(bus.code_valid), 0);
        key = '0;
        tick();
        bus.cmp_ready = 1'b0;
        pulseDone(1'b0, 1'b1);
        mFail = 1;
        checkOutput("wrong.fail", 32'(failCnt), 1);
        checkOutput("wrong.digits", 32'(digitsEntered), 0);

        // Return to zero failures, then three wrong attempts trigger lockout.
        doAttempt(16'h9999, 0, 1'b1, 1'b1, "preLock");
        doAttempt(16'h9999, 0, 1'b0, 1'b1, "lockA");
        doAttempt(16'h9999, 1, 1'b0, 1'b1, "lockB");
        doAttempt(16'h9999, 0, 1'b0, 1'b1, "lockC");

        // A match in between clears the failure history.
        doAttempt(16'h1111, 0, 1'b0, 1'b1, "succA");
        doAttempt(16'h2222, 0, 1'b0, 1'b1, "succB");
        doAttempt(16'h3333, 0, 1'b1, 1'b1, "succMatch");
        doAttempt(16'h4444, 0, 1'b0, 1'b1, "succAfter");
        checkOutput("succAfter.failOne", 32'(failCnt), 1);

        doAttempt(16'h4321, 10, 1'b0, 1'b0, "backpressure");

        // CLEAR discards partial entry; a multi-hot key adds nothing.
        pressDigit(5, 1);
        checkOutput("clr.one", 32'(digitsEntered), 1);
        applyStimulus(12'h006, 2);
        checkOutput("multiHot.digits", 32'(digitsEntered), 1);
        pressDigit(6, 1);
        checkOutput("clr.two", 32'(digitsEntered), 2);
        applyStimulus(12'h400, 1);
        checkOutput("clr.digits", 32'(digitsEntered), 0);
        checkOutput("clr.code", 32'(bus.code), 0);
        doAttempt(16'h0001, 2, 1'b1, 1'b1, "clrCode");

        pulseDone(1'b0, 1'b1);
        checkOutput("strayDone.fail", 32'(failCnt), 32'(mFail));

        // Reset while a code is being presented.
        enterAndSubmit(16'h7777, 0, "preRst");
        pulseDone(1'b1, 1'b1);
        mFail = 0;
        bus.cmp_ready = 1'b0;
        for (int i = 0; i < 4; i++) pressDigit(7, 1);
        checkOutput("rstReq.valid", 32'(bus.code_valid), 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("rstReq");
        tick();
        rst_n = 1'b1;
        tick();
        pulseDone(1'b0, 1'b1);
        checkOutput("rstReq.stray", 32'(failCnt), 0);
        checkOutput("rstReq.strayValid", 32'(bus.code_valid), 0);

        // Reset while locked out.
        doAttempt(16'h8888, 0, 1'b0, 1'b1, "rstLockA");
        doAttempt(16'h8888, 0, 1'b0, 1'b1, "rstLockB");
        enterAndSubmit(16'h8888, 0, "rstLockC");
        pulseDone(1'b0, 1'b1);
        checkOutput("rstLock.on", 32'(lockout), 1);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1 checkAllZero("rstLock");
        tick();
        rst_n = 1'b1;
        mFail = 0;
        tick();
        pulseDone(1'b0, 1'b1);
        checkOutput("rstLock.stray", 32'(failCnt), 0);

        // Random attempts against the attempt-level failure model.
        for (int a = 0; a < 14; a++) begin
            rc = '0;
            for (int d = 0; d < 4; d++) rc = {rc[11:0], 4'($urandom_range(0, 9))};
            doAttempt(rc, int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) != 0), $sformatf("rand%0d", a));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
